// File: rtl/waveform_output_serdes_if.sv
// Frame handshake between the waveform generator (master) and the DAC serializer (slave).
interface waveform_output_serdes_if #(
    parameter int unsigned LANE_W = 64,
    parameter int unsigned RATIO  = 3
);
    logic [RATIO*LANE_W-1:0] dac_i_data;
    logic                    dac_i_valid;
    logic                    dac_i_ready;

    modport master (output dac_i_data, output dac_i_valid, input dac_i_ready);
    modport slave  (input dac_i_data, input dac_i_valid, output dac_i_ready);
endinterface

// File: rtl/waveform_output_serdes.sv
// Serializes RATIO-slice frames onto one LANE_W DAC word per clock, LMFC-aligned at start-up,
// with idle-pattern fill on underflow and a saturating underflow counter.
module waveform_output_serdes #(
    parameter int unsigned       LANE_W    = 64,
    parameter int unsigned       RATIO     = 3,
    parameter logic [LANE_W-1:0] IDLE_DATA = {LANE_W{1'b0}}
) (
    input  logic                     dac_clk,
    input  logic                     rst,
    waveform_output_serdes_if.slave  dac_i,
    input  logic                     DAC_READY,
    input  logic                     DAC_LMFC,
    output logic [LANE_W-1:0]        dac_o_data,
    output logic                     dac_o_valid,
    input  logic                     underflow_clr,
    output logic [15:0]              underflow_cnt
);
    localparam int unsigned PW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [PW-1:0] LAST = PW'(RATIO - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                  state, state_nxt;
    logic [PW-1:0]           phase, phase_nxt, phase_inc;
    logic [RATIO*LANE_W-1:0] word_r, word_nxt;
    logic                    uf_r, uf_nxt;
    logic [LANE_W-1:0]       data_nxt;
    logic                    valid_nxt;
    logic [15:0]             cnt_nxt;
    logic                    ready_c;
    logic                    uf_evt;
    logic [LANE_W-1:0]       word_sl [RATIO];

    // Slice view of the held frame
    always_comb begin
        for (int k = 0; k < int'(RATIO); k++) begin
            word_sl[k] = word_r[k*LANE_W +: LANE_W];
        end
    end

    assign phase_inc         = phase + PW'(1);
    assign dac_i.dac_i_ready = ready_c & ~rst;

    always_ff @(posedge dac_clk) begin
        if (rst) begin
            state         <= S_IDLE;
            phase         <= '0;
            word_r        <= '0;
            uf_r          <= 1'b0;
            dac_o_data    <= IDLE_DATA;
            dac_o_valid   <= 1'b0;
            underflow_cnt <= 16'd0;
        end else begin
            state         <= state_nxt;
            phase         <= phase_nxt;
            word_r        <= word_nxt;
            uf_r          <= uf_nxt;
            dac_o_data    <= data_nxt;
            dac_o_valid   <= valid_nxt;
            underflow_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        word_nxt  = word_r;
        uf_nxt    = uf_r;
        data_nxt  = dac_o_data;
        valid_nxt = dac_o_valid;
        ready_c   = 1'b0;
        uf_evt    = 1'b0;

        case (state)
            S_IDLE: begin
                ready_c   = DAC_READY & DAC_LMFC;
                data_nxt  = IDLE_DATA;
                valid_nxt = 1'b0;
                if (ready_c && dac_i.dac_i_valid) begin
                    word_nxt  = dac_i.dac_i_data;
                    data_nxt  = dac_i.dac_i_data[LANE_W-1:0];
                    valid_nxt = 1'b1;
                    phase_nxt = '0;
                    uf_nxt    = 1'b0;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!DAC_READY) begin
                    // Link loss drops the frame; realignment needs a fresh LMFC in IDLE
                    state_nxt = S_IDLE;
                    data_nxt  = IDLE_DATA;
                    valid_nxt = 1'b0;
                    phase_nxt = '0;
                    word_nxt  = '0;
                    uf_nxt    = 1'b0;
                end else if (phase == LAST) begin
                    ready_c   = 1'b1;
                    phase_nxt = '0;
                    if (dac_i.dac_i_valid) begin
                        word_nxt  = dac_i.dac_i_data;
                        data_nxt  = dac_i.dac_i_data[LANE_W-1:0];
                        valid_nxt = 1'b1;
                        uf_nxt    = 1'b0;
                    end else begin
                        // Idle for a whole frame so the LMFC phase is preserved
                        uf_nxt    = 1'b1;
                        data_nxt  = IDLE_DATA;
                        valid_nxt = 1'b0;
                        uf_evt    = 1'b1;
                    end
                end else begin
                    phase_nxt = phase_inc;
                    data_nxt  = uf_r ? IDLE_DATA : word_sl[phase_inc];
                    valid_nxt = ~uf_r;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        cnt_nxt = underflow_cnt;
        if (underflow_clr) begin
            cnt_nxt = uf_evt ? 16'd1 : 16'd0;
        end else if (uf_evt && (underflow_cnt != 16'hFFFF)) begin
            cnt_nxt = underflow_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_waveform_output_serdes.sv
// Scoreboard bench: a RATIO=3/64-bit instance and a RATIO=1/32-bit instance.
module tb_waveform_output_serdes;
    typedef struct {
        logic [63:0] d;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst_a, rdy_a, lmfc_a, clr_a;
    logic [63:0] od_a;
    logic        ov_a;
    logic [15:0] cnt_a;
    logic        rst_b, rdy_b, lmfc_b, clr_b;
    logic [31:0] od_b;
    logic        ov_b;
    logic [15:0] cnt_b;

    int          checks   = 0;
    int          failures = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    logic [15:0] exp_cnt_a = 16'd0;
    logic [15:0] exp_cnt_b = 16'd0;

    waveform_output_serdes_if #(.LANE_W(64), .RATIO(3)) bus_a ();
    waveform_output_serdes_if #(.LANE_W(32), .RATIO(1)) bus_b ();

    waveform_output_serdes #(.LANE_W(64), .RATIO(3)) dut_a (
        .dac_clk(clk), .rst(rst_a), .dac_i(bus_a), .DAC_READY(rdy_a), .DAC_LMFC(lmfc_a),
        .dac_o_data(od_a), .dac_o_valid(ov_a), .underflow_clr(clr_a), .underflow_cnt(cnt_a)
    );

    waveform_output_serdes #(.LANE_W(32), .RATIO(1)) dut_b (
        .dac_clk(clk), .rst(rst_b), .dac_i(bus_b), .DAC_READY(rdy_b), .DAC_LMFC(lmfc_b),
        .dac_o_data(od_b), .dac_o_valid(ov_b), .underflow_clr(clr_b), .underflow_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc_a(input logic er);
        exp_t e;
        #1;
        check("ready_a", 64'(bus_a.dac_i_ready), 64'(er));
        @(posedge clk);
        #1;
        if (qa.size() > 0) e = qa.pop_front();
        else begin e.d = '0; e.v = 1'b0; end
        check("data_a", od_a, e.d);
        check("valid_a", 64'(ov_a), 64'(e.v));
        check("cnt_a", 64'(cnt_a), 64'(exp_cnt_a));
    endtask

    task automatic cyc_b(input logic er);
        exp_t e;
        #1;
        check("ready_b", 64'(bus_b.dac_i_ready), 64'(er));
        @(posedge clk);
        #1;
        if (qb.size() > 0) e = qb.pop_front();
        else begin e.d = '0; e.v = 1'b0; end
        check("data_b", 64'(od_b), e.d);
        check("valid_b", 64'(ov_b), 64'(e.v));
        check("cnt_b", 64'(cnt_b), 64'(exp_cnt_b));
    endtask

    task automatic push_frame_a(input logic [191:0] f);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.d = f[k*64 +: 64];
            e.v = 1'b1;
            qa.push_back(e);
        end
    endtask

    // One accept slot (phase 2) followed by the two mid-frame cycles
    task automatic frame_a(input logic v, input logic [191:0] f, input logic c);
        exp_t e;
        bus_a.dac_i_valid = v;
        bus_a.dac_i_data  = f;
        clr_a             = c;
        if (v) begin
            push_frame_a(f);
            if (c) exp_cnt_a = 16'd0;
        end else begin
            e.d = '0;
            e.v = 1'b0;
            for (int k = 0; k < 3; k++) qa.push_back(e);
            if (c) exp_cnt_a = 16'd1;
            else if (exp_cnt_a != 16'hFFFF) exp_cnt_a = exp_cnt_a + 16'd1;
        end
        cyc_a(1'b1);
        bus_a.dac_i_valid = 1'b0;
        clr_a             = 1'b0;
        cyc_a(1'b0);
        cyc_a(1'b0);
    endtask

    task automatic push_b(input logic [31:0] d);
        exp_t e;
        e.d = 64'(d);
        e.v = 1'b1;
        qb.push_back(e);
    endtask

    initial begin
        rst_a = 1'b1; rdy_a = 1'b1; lmfc_a = 1'b1; clr_a = 1'b0;
        bus_a.dac_i_valid = 1'b1; bus_a.dac_i_data = '1;
        rst_b = 1'b1; rdy_b = 1'b0; lmfc_b = 1'b0; clr_b = 1'b0;
        bus_b.dac_i_valid = 1'b0; bus_b.dac_i_data = '0;

        // Reset forces ready low even with READY & LMFC & valid high
        cyc_a(1'b0);
        cyc_a(1'b0);
        rst_a  = 1'b0;
        lmfc_a = 1'b0;
        repeat (10) cyc_a(1'b0);

        // LMFC-aligned start with {C,B,A}
        lmfc_a = 1'b1;
        bus_a.dac_i_data = {64'hC, 64'hB, 64'hA};
        push_frame_a({64'hC, 64'hB, 64'hA});
        cyc_a(1'b1);
        lmfc_a = 1'b0;
        bus_a.dac_i_valid = 1'b0;
        cyc_a(1'b0);
        cyc_a(1'b0);
        frame_a(1'b1, {64'hC1, 64'hB1, 64'hA1}, 1'b0);
        frame_a(1'b1, {64'hC2, 64'hB2, 64'hA2}, 1'b0);
        frame_a(1'b0, '0, 1'b0);
        frame_a(1'b1, {64'hC3, 64'hB3, 64'hA3}, 1'b0);

        // Link drops at phase 1: remaining slice is discarded
        bus_a.dac_i_valid = 1'b1;
        bus_a.dac_i_data  = {64'hC4, 64'hB4, 64'hA4};
        push_frame_a({64'hC4, 64'hB4, 64'hA4});
        cyc_a(1'b1);
        bus_a.dac_i_valid = 1'b0;
        cyc_a(1'b0);
        rdy_a = 1'b0;
        qa.delete();
        cyc_a(1'b0);
        rdy_a = 1'b1;
        bus_a.dac_i_valid = 1'b1;
        bus_a.dac_i_data  = {64'hC5, 64'hB5, 64'hA5};
        repeat (3) cyc_a(1'b0);
        lmfc_a = 1'b1;
        push_frame_a({64'hC5, 64'hB5, 64'hA5});
        cyc_a(1'b1);
        lmfc_a = 1'b0;
        bus_a.dac_i_valid = 1'b0;
        cyc_a(1'b0);
        cyc_a(1'b0);
        frame_a(1'b0, '0, 1'b0);
        frame_a(1'b0, '0, 1'b1);
        frame_a(1'b1, {64'hC6, 64'hB6, 64'hA6}, 1'b1);

        // RATIO=1 instance: back-to-back frames
        rst_b = 1'b0; rdy_b = 1'b1; lmfc_b = 1'b1;
        bus_b.dac_i_valid = 1'b1;
        bus_b.dac_i_data  = 32'd1;
        push_b(32'd1);
        cyc_b(1'b1);
        lmfc_b = 1'b0;
        bus_b.dac_i_data = 32'd2;
        push_b(32'd2);
        cyc_b(1'b1);
        bus_b.dac_i_data = 32'd3;
        push_b(32'd3);
        cyc_b(1'b1);

        // Every starved cycle is an underflow at RATIO=1; drive the counter to saturation
        bus_b.dac_i_valid = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        exp_cnt_b = 16'hFFFE;
        exp_cnt_b = 16'hFFFF;
        cyc_b(1'b1);
        cyc_b(1'b1);
        clr_b = 1'b1;
        exp_cnt_b = 16'd1;
        cyc_b(1'b1);
        bus_b.dac_i_valid = 1'b1;
        bus_b.dac_i_data  = 32'd9;
        push_b(32'd9);
        exp_cnt_b = 16'd0;
        cyc_b(1'b1);
        clr_b = 1'b0;
        bus_b.dac_i_data = 32'd10;
        push_b(32'd10);
        cyc_b(1'b1);

        // Reset mid-stream drops the frame and restores reset values
        rst_b = 1'b1;
        bus_b.dac_i_data = 32'd11;
        cyc_b(1'b0);
        rst_b = 1'b0;
        bus_b.dac_i_valid = 1'b0;
        cyc_b(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/waveform_output_serdes.md
# waveform_output_serdes

- Parametrised successor to the fixed 3:1 DAC waveform serializer.
- Accepts one wide frame of RATIO samples per handshake from the waveform generator and emits one LANE_W slice per `dac_clk` toward the JESD DAC transmit interface.
- Start-up is aligned to the first `DAC_LMFC` pulse seen while the link is ready.
- Adds a registered output, upstream valid/ready back-pressure, underflow filling with a fixed idle pattern, and a saturating underflow counter.

## Interface
- LANE_W, 64, width of one DAC output word.
- RATIO, 3, slices per input frame; legal range 1..16.
- IDLE_DATA, {LANE_W{1'b0}}, value driven on `dac_o_data` when not streaming or during underflow.
- dac_clk  in  1  single clock; every register uses its rising edge.
- rst  in  1  synchronous, active-high reset.
- dac_i_data  in  RATIO*LANE_W  input frame; slice k = bits [k*LANE_W +: LANE_W]; slice 0 goes out first.
- dac_i_valid  in  1  frame valid.
- dac_i_ready  out  1  frame accepted when valid & ready.
- DAC_READY  in  1  DAC link up.
- DAC_LMFC  in  1  LMFC alignment pulse.
- dac_o_data  out  LANE_W  registered DAC word.
- dac_o_valid  out  1  registered; high when `dac_o_data` carries frame data.
- underflow_clr  in  1  clears `underflow_cnt`.
- underflow_cnt  out  16  saturating count of underflow frames.

## Operation
- States: IDLE and RUN. There is a phase counter of clog2(RATIO) bits (minimum 1), a frame register word_r, and an underflow flag uf_r.
- **IDLE**
  - `dac_i_ready` = DAC_READY & DAC_LMFC (combinational).
  - On accept: load word_r, set `dac_o_data` = slice 0, `dac_o_valid` = 1, phase = 0, uf_r = 0, and move to RUN.
  - If valid is low while DAC_READY & DAC_LMFC are high, stay in IDLE and wait for the next LMFC pulse.
- **RUN**
  - Each cycle, phase advances by 1 and wraps from RATIO-1 to 0.
  - When the next phase is nonzero, `dac_o_data` = word_r slice (phase+1), or IDLE_DATA if uf_r is set.
  - `dac_i_ready` = (phase == RATIO-1) & DAC_READY.
  - At phase RATIO-1 with valid high: load the new frame, output its slice 0, clear uf_r. The stream is gap-free.
  - At phase RATIO-1 with valid low (underflow):
    - Set uf_r and output IDLE_DATA with `dac_o_valid` = 0 for one full frame (RATIO cycles), so LMFC frame alignment is kept.
    - Increment `underflow_cnt`, saturating at 16'hFFFF.
    - The next accept opportunity is again at phase RATIO-1.
  - DAC_READY low in any RUN cycle: next edge goes to IDLE, drives IDLE_DATA with `dac_o_valid` = 0, phase = 0, discards word_r. This is not counted as underflow.
- RATIO = 1: the phase is always 0 and ready equals DAC_READY in RUN; each accepted frame is output the next cycle.
- When underflow_clr and an increment occur in the same cycle, the count becomes 1. underflow_clr alone gives 0.

## Timing
- Reset values:
  - state IDLE, phase 0, uf_r 0, word_r 0.
  - `dac_o_data` = IDLE_DATA, `dac_o_valid` = 0, `underflow_cnt` = 0.
  - `dac_i_ready` is forced to 0 while rst is high.
- Latency: a frame accepted at edge N puts slice 0 on `dac_o_data` after edge N, and slice k after edge N+k.
- Throughput: one frame per RATIO cycles; sustained back-to-back frames give continuous `dac_o_valid`.
- `dac_i_ready` depends combinationally on DAC_READY and DAC_LMFC, and never on `dac_i_valid`.
- rst asserted mid-frame: all reset values hold from the next edge; the partial frame is dropped.
- `DAC_LMFC` is ignored in RUN. Realignment happens only through IDLE.

## Test plan
- Reset, then DAC_READY=1 with DAC_LMFC low for 10 cycles and valid high → ready=0, `dac_o_data`=0, `dac_o_valid`=0 throughout.
- LANE_W=64, RATIO=3. Pulse LMFC with frame {64'hC, 64'hB, 64'hA}, then frames every 3 cycles → output A,B,C,A',B',C' one cycle after accept, `dac_o_valid` continuously 1.
- Drop valid at one phase-2 slot → 3 cycles of IDLE_DATA with `dac_o_valid`=0 and `underflow_cnt`=1; the next frame starts exactly on a phase-0 boundary.
- DAC_READY falls at phase 1 → next cycle IDLE_DATA and valid 0; restart needs a fresh LMFC pulse and outputs slice 0 of the new frame.
- Force `underflow_cnt` to saturate at FFFF, then assert underflow_clr together with an underflow → count = 1; underflow_clr alone → 0.
- RATIO=1, LANE_W=32: back-to-back frames 1,2,3 → output 1,2,3 on consecutive cycles; assert rst mid-stream → outputs return to reset values after the next edge.
